// File: rtl/stack_controller_pkg.sv
// Shared opcodes, stack-pointer control encodings and FSM states for the
// hardware stack sequencer.
package stack_controller_pkg;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PEEK = 2'b10;

  // Bit 0 would put SP on the bus; this controller never does that.
  localparam logic [2:0] SP_HOLD = 3'b000;
  localparam logic [2:0] SP_DEC  = 3'b010;
  localparam logic [2:0] SP_INC  = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH_WR,
    ST_PUSH_INC,
    ST_POP_DEC,
    ST_POP_RD,
    ST_PEEK_INC,
    ST_RSP
  } state_e;

endpackage

// File: rtl/stack_occupancy.sv
// Saturating up/down occupancy counter with full/empty flags; the caller
// never raises inc and dec together.
module stack_occupancy #(
  parameter  int DEPTH = 256,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [CNT_W-1:0] count_q, count_d;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Guarded so a stray request can never wrap the counter.
  always_comb begin
    count_d = count_q;
    if (inc_i && !full_o) begin
      count_d = count_q + 1'b1;
    end else if (dec_i && !empty_o) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/stack_controller.sv
// Sequencer for the stack pointer and stack memory on the shared word bus:
// one command in, one response out, and at most one bus driver per cycle.
module stack_controller
  import stack_controller_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 256,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_data,
  output logic             o_cmd_ready,
  output logic             o_rsp_valid,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_rsp_err,
  input  logic             i_rsp_ready,
  inout  wire  [WIDTH-1:0] bus,
  output logic [2:0]       o_sp_ctrl,
  output logic             o_mem_w,
  output logic             o_mem_oe,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic             peek_q, peek_d;
  logic             bus_oe;
  logic             cnt_inc, cnt_dec;
  logic             reject;

  stack_occupancy #(.DEPTH(DEPTH)) u_occupancy (
    .clk_i   (i_clock),
    .rst_i   (i_reset),
    .inc_i   (cnt_inc),
    .dec_i   (cnt_dec),
    .count_o (o_count),
    .full_o  (o_full),
    .empty_o (o_empty)
  );

  assign reject = ((i_cmd_op == OP_PUSH) && o_full)
               || (((i_cmd_op == OP_POP) || (i_cmd_op == OP_PEEK)) && o_empty)
               || (i_cmd_op == 2'b11);

  // NOTE: every output of this block gets a default before the case, so no
  // state path can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    err_d     = err_q;
    peek_d    = peek_q;
    o_sp_ctrl = SP_HOLD;
    o_mem_w   = 1'b0;
    o_mem_oe  = 1'b0;
    bus_oe    = 1'b0;
    cnt_inc   = 1'b0;
    cnt_dec   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          peek_d = (i_cmd_op == OP_PEEK);
          if (reject) begin
            state_d = ST_RSP;
            err_d   = 1'b1;
            data_d  = '0;
          end else if (i_cmd_op == OP_PUSH) begin
            state_d = ST_PUSH_WR;
            err_d   = 1'b0;
            data_d  = i_cmd_data;
          end else begin
            state_d = ST_POP_DEC;
            err_d   = 1'b0;
          end
        end
      end
      ST_PUSH_WR: begin
        bus_oe  = 1'b1;
        o_mem_w = 1'b1;
        state_d = ST_PUSH_INC;
      end
      ST_PUSH_INC: begin
        o_sp_ctrl = SP_INC;
        cnt_inc   = 1'b1;
        state_d   = ST_RSP;
      end
      ST_POP_DEC: begin
        o_sp_ctrl = SP_DEC;
        cnt_dec   = 1'b1;
        state_d   = ST_POP_RD;
      end
      ST_POP_RD: begin
        o_mem_oe = 1'b1;
        data_d   = bus;
        state_d  = peek_q ? ST_PEEK_INC : ST_RSP;
      end
      ST_PEEK_INC: begin
        o_sp_ctrl = SP_INC;
        cnt_inc   = 1'b1;
        state_d   = ST_RSP;
      end
      ST_RSP: begin
        if (i_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value regardless of process evaluation order.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      err_q   <= 1'b0;
      peek_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      err_q   <= err_d;
      peek_q  <= peek_d;
    end
  end

  assign bus         = bus_oe ? data_q : 'z;
  assign o_cmd_ready = (state_q == ST_IDLE);
  assign o_rsp_valid = (state_q == ST_RSP);
  assign o_rsp_data  = data_q;
  assign o_rsp_err   = err_q;

endmodule

// File: tb/tb_stack_controller.sv
// Self-checking bench: a DEPTH=4 controller against a behavioural stack
// pointer/memory model and a response scoreboard.
module tb_stack_controller;
  import stack_controller_pkg::*;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  typedef struct packed {
    logic [W-1:0] data;
    logic         err;
  } rsp_t;

  logic          i_clock = 1'b0;
  logic          i_reset;
  logic          i_cmd_valid;
  logic [1:0]    i_cmd_op;
  logic [W-1:0]  i_cmd_data;
  logic          o_cmd_ready;
  logic          o_rsp_valid;
  logic [W-1:0]  o_rsp_data;
  logic          o_rsp_err;
  logic          i_rsp_ready;
  wire  [W-1:0]  bus;
  logic [2:0]    o_sp_ctrl;
  logic          o_mem_w;
  logic          o_mem_oe;
  logic [CW-1:0] o_count;
  logic          o_full;
  logic          o_empty;

  stack_controller #(.WIDTH(W), .DEPTH(D)) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_cmd_valid (i_cmd_valid),
    .i_cmd_op    (i_cmd_op),
    .i_cmd_data  (i_cmd_data),
    .o_cmd_ready (o_cmd_ready),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_err   (o_rsp_err),
    .i_rsp_ready (i_rsp_ready),
    .bus         (bus),
    .o_sp_ctrl   (o_sp_ctrl),
    .o_mem_w     (o_mem_w),
    .o_mem_oe    (o_mem_oe),
    .o_count     (o_count),
    .o_full      (o_full),
    .o_empty     (o_empty)
  );

  always #5 i_clock = ~i_clock;

  // Datapath model: stack pointer register and stack memory.
  int           sp;
  logic [W-1:0] mem [0:7];

  always @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sp <= 0;
    end else begin
      if (o_mem_w) mem[sp[2:0]] <= bus;
      if (o_sp_ctrl == SP_INC)      sp <= sp + 1;
      else if (o_sp_ctrl == SP_DEC) sp <= sp - 1;
    end
  end

  assign bus = o_mem_oe ? mem[sp[2:0]] : 'z;

  int           checks   = 0;
  int           failures = 0;
  int           memw_cycles = 0;
  rsp_t         exp_q [$];
  logic [W-1:0] ref_stk [$];
  logic [2:0]   tr_sp   [0:7];
  logic         tr_memw [0:7];
  logic [W-1:0] tr_bus  [0:7];

  // Per-cycle invariants: single bus driver, write only while controller drives.
  always @(negedge i_clock) begin
    if (!i_reset) begin
      checks++;
      if (o_sp_ctrl[0] !== 1'b0 || (o_mem_w && o_mem_oe) || o_sp_ctrl == 3'b110) begin
        failures++;
        $display("FAIL bus_excl: sp_ctrl=%b mem_w=%b mem_oe=%b required single driver",
                 o_sp_ctrl, o_mem_w, o_mem_oe);
      end
      checks++;
      if (o_full !== (o_count == CW'(D)) || o_empty !== (o_count == '0)) begin
        failures++;
        $display("FAIL flags: count=%0d full=%b empty=%b", o_count, o_full, o_empty);
      end
      if (o_mem_w) memw_cycles++;
    end
  end

  task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] d, input int hold);
    rsp_t exp;
    rsp_t got;
    int   exp_lat;
    int   lat;
    int   w;
    exp = '{data: '0, err: 1'b1};
    exp_lat = 0;
    case (op)
      OP_PUSH: if (ref_stk.size() < D) begin
        ref_stk.push_back(d); exp = '{data: d, err: 1'b0}; exp_lat = 2;
      end
      OP_POP: if (ref_stk.size() > 0) begin
        exp = '{data: ref_stk.pop_back(), err: 1'b0}; exp_lat = 2;
      end
      OP_PEEK: if (ref_stk.size() > 0) begin
        exp = '{data: ref_stk[$], err: 1'b0}; exp_lat = 3;
      end
      default: ;
    endcase
    exp_q.push_back(exp);

    @(negedge i_clock);
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_data  = d;
    w = 0;
    while (!o_cmd_ready && w < 20) begin
      @(negedge i_clock);
      w++;
    end
    checks++;
    if (!o_cmd_ready) begin
      failures++;
      $display("FAIL cmd_ready_timeout: ready=%b after %0d cycles, required 1", o_cmd_ready, w);
      i_cmd_valid = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    @(posedge i_clock);
    @(negedge i_clock);
    i_cmd_valid = 1'b0;

    lat = 0;
    while (!o_rsp_valid && lat < 20) begin
      tr_sp[lat[2:0]]   = o_sp_ctrl;
      tr_memw[lat[2:0]] = o_mem_w;
      tr_bus[lat[2:0]]  = bus;
      @(negedge i_clock);
      lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL latency op=%b: got %0d cycles, required %0d", op, lat, exp_lat);
    end
    if (!o_rsp_valid) begin
      void'(exp_q.pop_front());
      return;
    end

    for (int i = 0; i < hold; i++) begin
      checks++;
      if (!o_rsp_valid || o_cmd_ready || o_rsp_data !== exp_q[0].data || o_rsp_err !== exp_q[0].err) begin
        failures++;
        $display("FAIL rsp_hold cycle %0d: valid=%b ready=%b data=%h err=%b, required 1 0 %h %b",
                 i, o_rsp_valid, o_cmd_ready, o_rsp_data, o_rsp_err, exp_q[0].data, exp_q[0].err);
      end
      @(negedge i_clock);
    end

    got = '{data: o_rsp_data, err: o_rsp_err};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL rsp op=%b: got data=%h err=%b, required data=%h err=%b",
               op, got.data, got.err, exp.data, exp.err);
    end
    i_rsp_ready = 1'b1;
    @(posedge i_clock);
    @(negedge i_clock);
    i_rsp_ready = 1'b0;
    checks++;
    if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1 || o_count !== CW'(ref_stk.size())) begin
      failures++;
      $display("FAIL post_rsp: valid=%b ready=%b count=%0d, required 0 1 %0d",
               o_rsp_valid, o_cmd_ready, o_count, ref_stk.size());
    end
  endtask

  task automatic test_reset();
    i_reset     = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_op    = OP_PUSH;
    i_cmd_data  = '0;
    i_rsp_ready = 1'b0;
    repeat (2) @(negedge i_clock);
    i_reset = 1'b0;
    @(negedge i_clock);
    checks++;
    if (o_cmd_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_rsp_err !== 1'b0 || o_rsp_data !== '0) begin
      failures++;
      $display("FAIL reset_handshake: ready=%b valid=%b err=%b data=%h, required 1 0 0 0000",
               o_cmd_ready, o_rsp_valid, o_rsp_err, o_rsp_data);
    end
    checks++;
    if (o_sp_ctrl !== SP_HOLD || o_mem_w !== 1'b0 || o_mem_oe !== 1'b0 ||
        o_count !== '0 || o_empty !== 1'b1 || o_full !== 1'b0) begin
      failures++;
      $display("FAIL reset_datapath: sp_ctrl=%b mem_w=%b oe=%b count=%0d empty=%b full=%b",
               o_sp_ctrl, o_mem_w, o_mem_oe, o_count, o_empty, o_full);
    end
  endtask

  task automatic test_push_basic();
    do_cmd(OP_PUSH, 16'hA5A5, 0);
    checks++;
    if (tr_memw[0] !== 1'b1 || tr_bus[0] !== 16'hA5A5 || tr_sp[0] !== SP_HOLD) begin
      failures++;
      $display("FAIL push_wr: mem_w=%b bus=%h sp_ctrl=%b, required 1 a5a5 000",
               tr_memw[0], tr_bus[0], tr_sp[0]);
    end
    checks++;
    if (tr_sp[1] !== SP_INC || tr_memw[1] !== 1'b0) begin
      failures++;
      $display("FAIL push_inc: sp_ctrl=%b mem_w=%b, required 100 0", tr_sp[1], tr_memw[1]);
    end
  endtask

  task automatic test_lifo();
    do_cmd(OP_POP, 16'h0, 0);
    for (int i = 1; i <= 3; i++) do_cmd(OP_PUSH, W'(i), 0);
    for (int i = 0; i < 3; i++) do_cmd(OP_POP, 16'h0, 0);
    checks++;
    if (sp != 0 || o_empty !== 1'b1 || o_count !== '0) begin
      failures++;
      $display("FAIL lifo_balance: sp=%0d empty=%b count=%0d, required 0 1 0", sp, o_empty, o_count);
    end
  endtask

  task automatic test_peek();
    do_cmd(OP_PUSH, 16'h1234, 0);
    do_cmd(OP_PEEK, 16'h0, 0);
    checks++;
    if (tr_sp[0] !== SP_DEC || tr_sp[1] !== SP_HOLD || tr_sp[2] !== SP_INC) begin
      failures++;
      $display("FAIL peek_sp_seq: got %b %b %b, required 010 000 100", tr_sp[0], tr_sp[1], tr_sp[2]);
    end
    checks++;
    if (o_count !== CW'(1) || sp != 1) begin
      failures++;
      $display("FAIL peek_count: count=%0d sp=%0d, required 1 1", o_count, sp);
    end
    do_cmd(OP_POP, 16'h0, 0);
  endtask

  task automatic test_errors();
    int memw_before;
    do_cmd(OP_POP, 16'h0, 0);
    do_cmd(OP_PEEK, 16'h0, 0);
    do_cmd(2'b11, 16'hDEAD, 0);
    for (int i = 0; i < D; i++) do_cmd(OP_PUSH, W'(16'h100 + i), 0);
    checks++;
    if (o_full !== 1'b1) begin
      failures++;
      $display("FAIL full_flag: got %b, required 1", o_full);
    end
    memw_before = memw_cycles;
    do_cmd(OP_PUSH, 16'hBEEF, 0);
    checks++;
    if (memw_cycles != memw_before || sp != D) begin
      failures++;
      $display("FAIL overflow_touch: mem_w cycles=%0d sp=%0d, required 0 %0d",
               memw_cycles - memw_before, sp, D);
    end
    for (int i = 0; i < D; i++) do_cmd(OP_POP, 16'h0, 0);
  endtask

  task automatic test_rsp_hold();
    do_cmd(OP_PUSH, 16'h5A5A, 5);
  endtask

  task automatic test_reset_mid_push();
    int w;
    @(negedge i_clock);
    i_cmd_valid = 1'b1;
    i_cmd_op    = OP_PUSH;
    i_cmd_data  = 16'hC3C3;
    w = 0;
    while (!o_cmd_ready && w < 20) begin
      @(negedge i_clock);
      w++;
    end
    @(posedge i_clock);
    #1;
    i_cmd_valid = 1'b0;
    checks++;
    if (o_mem_w !== 1'b1) begin
      failures++;
      $display("FAIL mid_push_state: mem_w=%b, required 1", o_mem_w);
    end
    i_reset = 1'b1;
    #1;
    checks++;
    if (o_mem_w !== 1'b0 || o_mem_oe !== 1'b0 || o_cmd_ready !== 1'b1 || o_count !== '0) begin
      failures++;
      $display("FAIL async_reset: mem_w=%b oe=%b ready=%b count=%0d, required 0 0 1 0",
               o_mem_w, o_mem_oe, o_cmd_ready, o_count);
    end
    ref_stk.delete();
    @(posedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clock);
      checks++;
      if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1 || o_count !== '0 || sp != 0) begin
        failures++;
        $display("FAIL post_reset cycle %0d: valid=%b ready=%b count=%0d sp=%0d, required 0 1 0 0",
                 i, o_rsp_valid, o_cmd_ready, o_count, sp);
      end
    end
  endtask

  task automatic test_random();
    int r;
    logic [1:0] op;
    for (int n = 0; n < 1000; n++) begin
      r  = $urandom_range(0, 9);
      op = (r < 4) ? OP_PUSH : (r < 7) ? OP_POP : (r < 9) ? OP_PEEK : 2'b11;
      do_cmd(op, W'($urandom), $urandom_range(0, 2));
    end
    checks++;
    if (sp != ref_stk.size()) begin
      failures++;
      $display("FAIL random_sp: sp=%0d, required %0d", sp, ref_stk.size());
    end
  endtask

  initial begin
    test_reset();
    test_push_basic();
    test_lifo();
    test_peek();
    test_errors();
    test_rsp_hold();
    test_reset_mid_push();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_controller.md
Name: stack_controller

Overview:
Sequencing master for the hardware stack datapath: the stack pointer register and the stack memory on the shared 16-bit word bus.
- Accepts PUSH/POP/PEEK commands over a valid/ready handshake and returns one response per command.
- Generates the per-cycle bus drive, write and stack-pointer controls, so at most one bus driver exists per cycle.
- Tracks occupancy and rejects overflow/underflow without touching the datapath.

Parameters:
WIDTH, 16, data/bus word width
DEPTH, 256, maximum stack entries; occupancy counter width is clog2(DEPTH+1)

Ports:
i_clock  input  1  system clock, all state on rising edge
i_reset  input  1  asynchronous active-high reset
i_cmd_valid  input  1  command present
i_cmd_op  input  2  00 PUSH, 01 POP, 10 PEEK, 11 reserved (treated as error)
i_cmd_data  input  WIDTH  push data
o_cmd_ready  output  1  command accepted when valid&ready at clock edge
o_rsp_valid  output  1  response present
o_rsp_data  output  WIDTH  popped/peeked word; pushed word for PUSH; 0 on error
o_rsp_err  output  1  overflow/underflow/reserved op
i_rsp_ready  input  1  response consumed when valid&ready at edge
bus  inout  WIDTH  shared word bus; driven only in PUSH_WR, else Z
o_sp_ctrl  output  3  to stack pointer: [0] drive SP onto bus (always 0 here), [1]=1,[2]=0 decrement, [1]=0,[2]=1 increment, 00 hold
o_mem_w  output  1  stack memory write at current SP address, data from bus
o_mem_oe  output  1  stack memory drives bus with word at current SP address
o_count  output  clog2(DEPTH+1)  current occupancy
o_full  output  1  o_count==DEPTH
o_empty  output  1  o_count==0

Behaviour:
- Reset values: FSM IDLE, o_count 0, o_cmd_ready 1, o_rsp_valid 0, o_rsp_err 0, o_rsp_data 0, o_sp_ctrl 000, o_mem_w 0, o_mem_oe 0, bus Z.
- Reset takes effect immediately, mid-operation included. The partially executed command is abandoned and no response is produced.
- Integration requirement: the stack pointer is reset to its base in the same reset event.
- Stack convention is empty-ascending: SP addresses the next free slot.
- FSM states: IDLE, PUSH_WR, PUSH_INC, POP_DEC, POP_RD, PEEK_INC, RSP. o_cmd_ready=1 only in IDLE.
- PUSH accepted with !o_full:
  - PUSH_WR (1 cycle): bus=i_cmd_data latched at accept, o_mem_w=1.
  - PUSH_INC (1 cycle): o_sp_ctrl=increment, count+1.
  - RSP with data=pushed word, err=0.
- POP accepted with !o_empty:
  - POP_DEC (1 cycle): o_sp_ctrl=decrement, count-1.
  - POP_RD (1 cycle): o_mem_oe=1, bus sampled into o_rsp_data at cycle end.
  - RSP.
- PEEK with !o_empty: POP_DEC, POP_RD, then PEEK_INC (o_sp_ctrl=increment, count restored), then RSP.
- Error cases go IDLE -> RSP directly on the accept edge with err=1, data=0, and no datapath control asserted:
  - PUSH when full
  - POP/PEEK when empty
  - op 11
- RSP: o_rsp_valid=1, hold data/err stable until i_rsp_ready; on handshake edge -> IDLE.
- Latency from accept edge to o_rsp_valid: PUSH 2, POP 2, PEEK 3, error 0 cycles after the edge (visible in the following cycle).
- No back-to-back throughput: the next command is accepted no earlier than the edge after the response handshake.
- Bus exclusivity invariant: (bus driven by controller) + o_mem_oe + o_sp_ctrl[0] <= 1 every cycle.
- o_mem_w is only ever high together with the controller driving the bus.
- o_count never wraps. o_full/o_empty are combinational from o_count.

Decomposition:
- Shared package: opcode constants (OP_PUSH, OP_POP, OP_PEEK), SP control encodings (SP_HOLD, SP_INC, SP_DEC), FSM state enum.
- One natural sub-module: stack_occupancy, the up/down counter with full/empty flags. It is parameterised by DEPTH, with inc/dec inputs that are mutually exclusive by construction.

Test Plan:
- Reset, PUSH 16'hA5A5 -> PUSH_WR cycle: bus=A5A5, o_mem_w=1. Next cycle o_sp_ctrl=inc. Then rsp valid, data A5A5, err 0, o_count 1.
- PUSH 1,2,3 then POP x3 -> responses 3,2,1. o_count returns to 0, o_empty=1. SP net movement zero, checked with the datapath model.
- PEEK after PUSH 16'h1234 -> rsp 1234, o_count stays 1. o_sp_ctrl sequence is dec, hold, inc. A subsequent POP returns 1234.
- DEPTH=4 variant: 5 PUSHes -> 5th gets err=1, data 0, o_mem_w never high. POP on empty -> err=1. op 11 -> err=1.
- Hold i_rsp_ready=0 for 5 cycles -> o_rsp_valid, data and err stable, o_cmd_ready=0 throughout. Assert bus-exclusivity invariant every cycle of a random 1000-command run.
- Assert i_reset during PUSH_WR -> same timestep: o_mem_w=0, bus Z. After release: IDLE, o_count 0, no response emitted.
